// File: rtl/mlp_ctrl_pkg.sv
// Shared layer codes and FSM state encoding for the MLP test-bench sequencer.
package mlp_ctrl_pkg;

  localparam logic [1:0] LAYER_IDLE   = 2'd0;
  localparam logic [1:0] LAYER_HIDDEN = 2'd1;
  localparam logic [1:0] LAYER_OUTPUT = 2'd2;
  localparam logic [1:0] LAYER_SCORE  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StHidden,
    StOutput,
    StScore,
    StDone
  } state_e;

endpackage

// File: rtl/mlp_slot_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
module mlp_slot_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  input  logic [Width-1:0] term_val_i,
  output logic [Width-1:0] count_o,
  output logic             term_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == term_val_i);

endmodule

// File: rtl/mlp_controller.sv
// Sequences the MLP wrapper through hidden slots, output wait and one scoring cycle per test case.
module mlp_controller
  import mlp_ctrl_pkg::*;
#(
  parameter int unsigned size_of_hidden_layer       = 30,
  parameter int unsigned clog2_size_of_hidden_layer = 5,
  parameter int unsigned number_of_test_cases       = 750,
  parameter int unsigned clog2_number_of_test_cases = 10,
  parameter int unsigned hidden_wait_cycles         = 1,
  parameter int unsigned output_wait_cycles         = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  output logic [1:0]                            curr_layer,
  output logic [size_of_hidden_layer-1:0]       ld_en,
  output logic                                  inc_addr,
  output logic                                  busy,
  output logic                                  done,
  output logic [clog2_number_of_test_cases-1:0] case_idx
);

  localparam int unsigned KW      = clog2_size_of_hidden_layer;
  localparam int unsigned CW      = clog2_number_of_test_cases;
  localparam int unsigned SlotMax = (hidden_wait_cycles > output_wait_cycles) ?
                                    hidden_wait_cycles : output_wait_cycles;
  localparam int unsigned SlotW   = (SlotMax > 1) ? $clog2(SlotMax) : 1;

  localparam logic [SlotW-1:0] HiddenTerm = SlotW'(hidden_wait_cycles - 1);
  localparam logic [SlotW-1:0] OutputTerm = SlotW'(output_wait_cycles - 1);
  localparam logic [KW-1:0]    KTerm      = KW'(size_of_hidden_layer - 1);
  localparam logic [CW-1:0]    CaseTerm   = CW'(number_of_test_cases - 1);
  localparam logic [size_of_hidden_layer-1:0] LdOne = size_of_hidden_layer'(1);

  state_e state_q, state_d;

  logic             slot_clr, slot_en, slot_term;
  logic [SlotW-1:0] slot_term_val, slot_count;
  logic             k_clr, k_en, k_term;
  logic [KW-1:0]    k_count;
  logic             case_clr, case_en, case_term;

  // One timer paces both hidden slots and the output wait; its terminal depends on the state.
  mlp_slot_timer #(.Width(SlotW)) u_slot_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (slot_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (slot_en),
    .term_val_i (slot_term_val),
    .count_o    (slot_count),
    .term_o     (slot_term)
  );

  mlp_slot_timer #(.Width(KW)) u_neuron_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (k_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (k_en),
    .term_val_i (KTerm),
    .count_o    (k_count),
    .term_o     (k_term)
  );

  mlp_slot_timer #(.Width(CW)) u_case_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (case_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (case_en),
    .term_val_i (CaseTerm),
    .count_o    (case_idx),
    .term_o     (case_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    slot_clr      = 1'b0;
    slot_en       = 1'b0;
    slot_term_val = HiddenTerm;
    k_clr         = 1'b0;
    k_en          = 1'b0;
    case_clr      = 1'b0;
    case_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        slot_clr = 1'b1;
        k_clr    = 1'b1;
        case_clr = 1'b1;
        if (start) state_d = StHidden;
      end
      StHidden: begin
        slot_en = 1'b1;
        if (slot_term) begin
          slot_clr = 1'b1;
          if (k_term) state_d = StOutput;
          else        k_en    = 1'b1;
        end
      end
      StOutput: begin
        slot_term_val = OutputTerm;
        slot_en       = 1'b1;
        if (slot_term) begin
          slot_clr = 1'b1;
          state_d  = StScore;
        end
      end
      StScore: begin
        k_clr = 1'b1;
        if (case_term) begin
          state_d = StDone;
        end else begin
          case_en = 1'b1;
          state_d = StHidden;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    curr_layer = LAYER_IDLE;
    ld_en      = '0;
    inc_addr   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      StHidden: begin
        curr_layer = LAYER_HIDDEN;
        busy       = 1'b1;
        if (slot_term) ld_en = LdOne << k_count;
      end
      StOutput: begin
        curr_layer = LAYER_OUTPUT;
        busy       = 1'b1;
      end
      StScore: begin
        curr_layer = LAYER_SCORE;
        busy       = 1'b1;
        inc_addr   = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
